// File: rtl/line_burst_adapter_pkg.sv
// Shared types and constants for line_burst_adapter.
// Holds the FSM state encoding, the default line/beat widths and the line
// address alignment helper used by the adapter and its interfaces.
package line_adapter_pkg;

  localparam int DEFAULT_LINE_W   = 256;
  localparam int DEFAULT_BEAT_W   = 64;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int ADDR_W           = 32;

  // Clears the byte-in-line offset bits of an address.
  localparam logic [ADDR_W-1:0] LINE_ADDR_MASK = {ADDR_W{1'b1}} << LINE_OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    RD_RESP,
    WR_BEAT,
    WR_RESP
  } state_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & LINE_ADDR_MASK;
  endfunction

endpackage

// File: rtl/line_burst_adapter_if.sv
// Bus interfaces of line_burst_adapter.
// line_port_if : line-level port, master = cache arbiter, slave = adapter.
// bmem_if      : 64-bit burst memory port, master = adapter, slave = memory.
interface line_port_if
  import line_adapter_pkg::*;
#(
  parameter int LINE_W = DEFAULT_LINE_W
);
  logic [ADDR_W-1:0] line_addr;
  logic              line_read;
  logic              line_write;
  logic [LINE_W-1:0] line_wdata;
  logic              line_ready;
  logic [LINE_W-1:0] line_rdata;
  logic              line_rvalid;
  logic              line_wdone;
  logic              proto_err;

  modport master (
    output line_addr, line_read, line_write, line_wdata,
    input  line_ready, line_rdata, line_rvalid, line_wdone, proto_err
  );

  modport slave (
    input  line_addr, line_read, line_write, line_wdata,
    output line_ready, line_rdata, line_rvalid, line_wdone, proto_err
  );
endinterface

interface bmem_if
  import line_adapter_pkg::*;
#(
  parameter int BEAT_W = DEFAULT_BEAT_W
);
  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [ADDR_W-1:0] bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/line_burst_adapter_beat_shifter.sv
// beat_shifter: indexed beat access into a cache line.
// Selects the outgoing write beat from the write line and builds the next
// read line with the incoming beat inserted, both at the same beat index.
module beat_shifter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int IDX_W  = 2
) (
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [LINE_W-1:0] i_wline,
  input  logic [LINE_W-1:0] i_rline,
  input  logic [BEAT_W-1:0] i_rbeat,
  output logic [BEAT_W-1:0] o_wbeat,
  output logic [LINE_W-1:0] o_rline
);
  localparam int BEATS = LINE_W / BEAT_W;

  // Beat select / beat insert; beat 0 occupies the least significant bits.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_wbeat = '0;
    o_rline = i_rline;
    for (int k = 0; k < BEATS; k++) begin
      if (i_idx == IDX_W'(k)) begin
        o_wbeat                       = i_wline[k*BEAT_W +: BEAT_W];
        o_rline[k*BEAT_W +: BEAT_W]   = i_rbeat;
      end
    end
  end

endmodule

// File: rtl/line_burst_adapter.sv
// line_burst_adapter: 256-bit line port to 64-bit burst memory bridge.
// Reads gather BEATS beats into one line; writes split a line into BEATS beats.
// One transaction outstanding; line_ready is the backpressure to the arbiter.
// Optional macro LINE_ADAPTER_RADDR_CHECK_EN: compare bmem_raddr against the
// latched line address on every captured read beat and flag mismatches.
module line_burst_adapter
  import line_adapter_pkg::*;
#(
  parameter int LINE_W = DEFAULT_LINE_W,
  parameter int BEAT_W = DEFAULT_BEAT_W
) (
  input  logic       clk,
  input  logic       rst,
  line_port_if.slave line_if,
  bmem_if.master     bmem
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_beat_cnt;
  logic [ADDR_W-1:0]  r_addr_q;
  logic [LINE_W-1:0]  r_wline;
  logic [LINE_W-1:0]  r_line_rdata;
  logic               r_bmem_read;
  logic               r_bmem_write;
  logic               r_rvalid;
  logic               r_wdone;
  logic               r_proto_err;

  logic               w_line_ready;
  logic               w_req;
  logic               w_accept;
  logic               w_raddr_err;
  logic [BEAT_W-1:0]  w_wbeat;
  logic [LINE_W-1:0]  w_rline_next;

  // Ready is suppressed while reset is held so every output reads zero.
  assign w_line_ready = (r_state == IDLE) && bmem.bmem_ready && !rst;
  assign w_req        = line_if.line_read || line_if.line_write;
  assign w_accept     = w_req && w_line_ready;

`ifdef LINE_ADAPTER_RADDR_CHECK_EN
  assign w_raddr_err = (bmem.bmem_raddr != r_addr_q);
`else
  assign w_raddr_err = 1'b0;
`endif

  beat_shifter #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .IDX_W  (IDX_W)
  ) u_beat_shifter (
    .i_idx   (r_beat_cnt),
    .i_wline (r_wline),
    .i_rline (r_line_rdata),
    .i_rbeat (bmem.bmem_rdata),
    .o_wbeat (w_wbeat),
    .o_rline (w_rline_next)
  );

  assign line_if.line_ready  = w_line_ready;
  assign line_if.line_rdata  = r_line_rdata;
  assign line_if.line_rvalid = r_rvalid;
  assign line_if.line_wdone  = r_wdone;
  assign line_if.proto_err   = r_proto_err;

  // r_addr_q is cleared on return to IDLE, so it doubles as bmem_addr.
  assign bmem.bmem_addr  = r_addr_q;
  assign bmem.bmem_read  = r_bmem_read;
  assign bmem.bmem_write = r_bmem_write;
  assign bmem.bmem_wdata = w_wbeat;

  // Transaction FSM with registered command, response and error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the line registers are reset too, so a reset discards any partial line and line_rdata reads zero.
      r_state      <= IDLE;
      r_beat_cnt   <= '0;
      r_addr_q     <= '0;
      r_wline      <= '0;
      r_line_rdata <= '0;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_rvalid     <= 1'b0;
      r_wdone      <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values; later ones in this block override defaults.
      r_rvalid <= 1'b0;
      r_wdone  <= 1'b0;

      // Requests are dropped while busy; read beats are only legal in RD_DATA.
      if (w_req && !w_line_ready)
        r_proto_err <= 1'b1;
      if (bmem.bmem_rvalid && (r_state != RD_DATA))
        r_proto_err <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr_q <= line_align(line_if.line_addr);
            if (line_if.line_write) begin
              r_wline      <= line_if.line_wdata;
              r_beat_cnt   <= '0;
              r_bmem_write <= 1'b1;
              r_state      <= WR_BEAT;
              if (line_if.line_read)
                r_proto_err <= 1'b1;
            end else begin
              r_bmem_read <= 1'b1;
              r_state     <= RD_REQ;
            end
          end
        end

        RD_REQ: begin
          if (bmem.bmem_ready) begin
            r_bmem_read <= 1'b0;
            r_beat_cnt  <= '0;
            r_state     <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (bmem.bmem_rvalid) begin
            r_line_rdata <= w_rline_next;
            if (w_raddr_err)
              r_proto_err <= 1'b1;
            if (r_beat_cnt == LAST_BEAT) begin
              r_rvalid <= 1'b1;
              r_state  <= RD_RESP;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end

        RD_RESP: begin
          r_addr_q <= '0;
          r_state  <= IDLE;
        end

        WR_BEAT: begin
          if (bmem.bmem_ready) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_bmem_write <= 1'b0;
              r_wdone      <= 1'b1;
              r_state      <= WR_RESP;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end

        WR_RESP: begin
          r_addr_q <= '0;
          r_state  <= IDLE;
        end

        default: begin
          r_addr_q     <= '0;
          r_bmem_read  <= 1'b0;
          r_bmem_write <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed and randomized bench for line_burst_adapter.
// The reference view is transaction level: a read line is the concatenation of
// the beats handed in, a write emits the line's 64-bit slices in order 0..3,
// and proto_err is a sticky flag the bench raises whenever it breaks protocol.
module tb_line_burst_adapter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic exp_err;

  line_port_if lif ();
  bmem_if      bif ();

  line_burst_adapter dut (
    .clk     (clk),
    .rst     (rst),
    .line_if (lif),
    .bmem    (bif)
  );

  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read transaction: command, optional command stall, two idle cycles, then
  // n_beats beats with random gaps. A full read checks the response.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                         input logic [31:0] raddr, input int stall, input int n_beats);
    logic [31:0] al;
    al = addr & 32'hFFFF_FFE0;
    @(negedge clk);
    lif.line_addr  = addr;
    lif.line_read  = 1'b1;
    bif.bmem_ready = 1'b1;
    @(negedge clk);
    lif.line_read = 1'b0;
    check("rd_cmd", bif.bmem_read, 1);
    check("rd_addr", bif.bmem_addr, al);
    check("rd_busy", lif.line_ready, 0);
    bif.bmem_ready = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("rd_cmd_hold", bif.bmem_read, 1);
      if (i == stall - 1) bif.bmem_ready = 1'b1;
    end
    @(negedge clk);
    check("rd_cmd_once", bif.bmem_read, 0);
    @(negedge clk);
    check("rd_cmd_once2", bif.bmem_read, 0);
    for (int b = 0; b < n_beats; b++) begin
      bif.bmem_rvalid = 1'b1;
      bif.bmem_rdata  = line[b*64 +: 64];
      bif.bmem_raddr  = raddr;
      @(negedge clk);
      bif.bmem_rvalid = 1'b0;
      if (b < 3) begin
        check("rd_rvalid_early", lif.line_rvalid, 0);
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          check("rd_gap", lif.line_rvalid, 0);
        end
      end
    end
    if (n_beats < 4) return;
    check("rd_rvalid", lif.line_rvalid, 1);
    check("rd_line", lif.line_rdata, line);
    @(negedge clk);
    check("rd_rvalid_pulse", lif.line_rvalid, 0);
    check("rd_idle_addr", bif.bmem_addr, 0);
    check("rd_ready", lif.line_ready, 1);
    check("rd_err", lif.proto_err, exp_err);
  endtask

  // Write transaction: mask bit c low-stalls burst cycle c; a line_read can be
  // injected at cycle inject_cyc, or issued together with the write (both).
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                          input logic [7:0] mask, input int inject_cyc, input logic both);
    logic [31:0] al;
    int          idx;
    int          cyc;
    logic        rdy;
    al = addr & 32'hFFFF_FFE0;
    @(negedge clk);
    lif.line_addr  = addr;
    lif.line_write = 1'b1;
    lif.line_wdata = line;
    lif.line_read  = both;
    bif.bmem_ready = 1'b1;
    @(negedge clk);
    lif.line_write = 1'b0;
    lif.line_read  = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 40) begin
      check("wr_valid", bif.bmem_write, 1);
      check("wr_data", bif.bmem_wdata, line[idx*64 +: 64]);
      check("wr_addr", bif.bmem_addr, al);
      check("wr_no_rd", bif.bmem_read, 0);
      check("wr_busy", lif.line_ready, 0);
      rdy = (cyc < 8) ? !mask[cyc] : 1'b1;
      bif.bmem_ready = rdy;
      lif.line_read  = (cyc == inject_cyc);
      @(negedge clk);
      lif.line_read = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    check("wr_beats", idx, 4);
    bif.bmem_ready = 1'b1;
    check("wr_done", lif.line_wdone, 1);
    check("wr_valid_end", bif.bmem_write, 0);
    @(negedge clk);
    check("wr_done_pulse", lif.line_wdone, 0);
    check("wr_ready", lif.line_ready, 1);
    check("wr_no_rvalid", lif.line_rvalid, 0);
    check("wr_err", lif.proto_err, exp_err);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    #1;
    check("rst_err_clear", lif.proto_err, 0);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom();
    return l;
  endfunction

  initial begin
    logic [255:0] line;
    logic [31:0]  addr;

    rst             = 1'b1;
    exp_err         = 1'b0;
    lif.line_addr   = '0;
    lif.line_read   = 1'b0;
    lif.line_write  = 1'b0;
    lif.line_wdata  = '0;
    bif.bmem_ready  = 1'b0;
    bif.bmem_raddr  = '0;
    bif.bmem_rdata  = '0;
    bif.bmem_rvalid = 1'b0;

    // Reset state.
    #12;
    check("rst_ready", lif.line_ready, 0);
    check("rst_rdata", lif.line_rdata, 0);
    check("rst_rvalid", lif.line_rvalid, 0);
    check("rst_wdone", lif.line_wdone, 0);
    check("rst_err", lif.proto_err, 0);
    check("rst_bmem_addr", bif.bmem_addr, 0);
    check("rst_bmem_read", bif.bmem_read, 0);
    check("rst_bmem_write", bif.bmem_write, 0);
    check("rst_bmem_wdata", bif.bmem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    bif.bmem_ready = 1'b1;
    #1;
    check("idle_ready", lif.line_ready, 1);

    // Directed read: beats 1..4, beat 0 in the LSBs.
    line = {64'd4, 64'd3, 64'd2, 64'd1};
    do_read(32'h1ECE_B014, line, 32'h1ECE_B000, 0, 4);

    // Directed write with bmem_ready low in the second beat cycle.
    for (int k = 0; k < 4; k++) line[k*64 +: 64] = 64'hA5A5_A5A5_0000_0000 | (64'(k) * 64'h1111);
    do_write(32'h0000_1234, line, 8'b0000_0010, -1, 1'b0);

    // Randomized mix of clean reads and writes.
    for (int t = 0; t < 8; t++) begin
      addr = $urandom();
      line = rand_line();
      if ($urandom_range(0, 1) == 1)
        do_read(addr, line, addr & 32'hFFFF_FFE0, $urandom_range(0, 2), 4);
      else
        do_write(addr, line, 8'($urandom_range(0, 255)), -1, 1'b0);
    end

    // Read-address tag mismatch on the returning beats.
`ifdef LINE_ADAPTER_RADDR_CHECK_EN
    exp_err = 1'b1;
`endif
    do_read(32'h0000_0020, rand_line(), 32'h0000_0040, 0, 4);
    pulse_reset();

    // Read issued while a write burst is in progress is dropped.
    exp_err = 1'b1;
    do_write($urandom(), rand_line(), 8'h00, 1, 1'b0);
    pulse_reset();

    // Read and write in the same cycle: write wins.
    exp_err = 1'b1;
    do_write($urandom(), rand_line(), 8'($urandom_range(0, 255)), -1, 1'b1);
    pulse_reset();

    // Asynchronous reset between clock edges after two read beats.
    do_read(32'h0000_4F00, rand_line(), 32'h0000_4F00, 0, 2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rdata", lif.line_rdata, 0);
    check("arst_rvalid", lif.line_rvalid, 0);
    check("arst_wdone", lif.line_wdone, 0);
    check("arst_ready", lif.line_ready, 0);
    check("arst_err", lif.proto_err, 0);
    check("arst_bmem_addr", bif.bmem_addr, 0);
    check("arst_bmem_read", bif.bmem_read, 0);
    check("arst_bmem_write", bif.bmem_write, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_resp", lif.line_rvalid, 0);
      check("post_rst_rdata", lif.line_rdata, 0);
    end
    line = rand_line();
    do_read(32'h0000_8000, line, 32'h0000_8000, 1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_burst_adapter.md
Name: line_burst_adapter

Overview:
Responder for the arbiter's line-level memory port, and initiator on the 64-bit burst memory (bmem) interface. It takes one 256-bit line read or write request at a time from the cache arbiter. Reads collect 4 beats into a 256-bit line for the arbiter. Writes split the line into 4 beats. It sits between cache_arbiter and the bmem model/DRAM controller.

Parameters:
LINE_W, 256, cache line width in bits
BEAT_W, 64, bmem data beat width in bits; BEATS = LINE_W/BEAT_W (4), must be a power of two

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
line_addr  input  32  arbiter request address; the low 5 bits are ignored
line_read  input  1  one-cycle read request pulse
line_write  input  1  one-cycle write request pulse
line_wdata  input  LINE_W  write line; sampled with line_write
line_ready  output  1  high when a request can be accepted; equals (state==IDLE) && bmem_ready
line_rdata  output  LINE_W  assembled read line
line_rvalid  output  1  one-cycle pulse: read line complete
line_wdone  output  1  one-cycle pulse: write burst complete
proto_err  output  1  sticky protocol-error flag
bmem_addr  output  32  line-aligned burst address
bmem_read  output  1  read command
bmem_write  output  1  write beat valid
bmem_wdata  output  BEAT_W  write beat data
bmem_ready  input  1  memory accepts a command or beat this cycle
bmem_raddr  input  32  address tag of the returning read data
bmem_rdata  input  BEAT_W  read beat data
bmem_rvalid  input  1  read beat valid

Behaviour:
- Reset (async, immediate): state=IDLE, beat_cnt=0, all outputs 0, line_rdata=0, proto_err=0. Any partial line is discarded and no response is issued.
- Address latch: addr_q={line_addr[31:5],5'b0}. bmem_addr is driven from addr_q in every non-IDLE state and is 0 in IDLE.
- States: IDLE, RD_REQ, RD_DATA, RD_RESP, WR_BEAT, WR_RESP.
- IDLE: accepts a request only when a request is present and line_ready is high.
  - line_read -> latch the address, go to RD_REQ.
  - line_write -> latch the address and line_wdata, go to WR_BEAT.
  - Both asserted together -> write wins and proto_err is set.
  - A request while line_ready is low is dropped and proto_err is set.
- RD_REQ: bmem_read=1 until a cycle with bmem_ready=1, then go to RD_DATA with beat_cnt=0. The command is held, never re-pulsed.
- RD_DATA: on each bmem_rvalid, bmem_rdata goes to line_rdata[beat_cnt*64 +: 64] and beat_cnt increments. Beat 0 is the LSBs. When beat BEATS-1 is captured, go to RD_RESP. Gaps between beats are allowed.
- RD_RESP: line_rvalid=1 for exactly one cycle, then IDLE. line_rdata holds until the next read's first beat overwrites it. Read latency from command accept to line_rvalid is the last-beat cycle + 1.
- WR_BEAT: bmem_write=1 and bmem_wdata=wline_q[beat_cnt*64 +: 64]. The beat advances only when bmem_ready=1; if bmem_ready=0 the same beat is held. After beat BEATS-1 is accepted, go to WR_RESP.
- WR_RESP: line_wdone=1 for one cycle, then IDLE. The minimum write is 4 beat cycles + 1 response cycle.
- bmem_rvalid outside RD_DATA: the beat is ignored and proto_err is set.
- beat_cnt is log2(BEATS) bits wide and is cleared on entry to RD_DATA and WR_BEAT. There is no wrap past BEATS-1.
- Only one outstanding transaction. line_ready low in all non-IDLE states is the arbiter's backpressure.

Optional Feature:
LINE_ADAPTER_RADDR_CHECK_EN
- Defined: on every accepted bmem_rvalid beat, bmem_raddr is compared to addr_q. A mismatch sets proto_err and the beat is still captured.
- Undefined: bmem_raddr is unused and there is no comparison logic. The port stays present.

Decomposition:
- Shared package line_adapter_pkg:
  - state enum typedef.
  - LINE_W/BEAT_W defaults.
  - LINE_OFFSET_BITS=5.
- One sub-module, beat_shifter: selects the write beat and inserts the read beat from a beat index. It is purely indexed and shared by both paths.
- The FSM stays in the top module.

Test Plan:
- Read: line_read at 0x1ECEB014; 2 cycles after the command is accepted, rvalid beats 0x0..01, 0x0..02, 0x0..03, 0x0..04 arrive. Required: bmem_addr=0x1ECEB000, one bmem_read accept, line_rdata=0x0..04_0..03_0..02_0..01, line_rvalid pulse one cycle after beat 4.
- Write with stall: line_write of pattern A5A5 (beat k = k*0x1111), with bmem_ready low in the 2nd beat cycle. Required: beat 1 repeats with the same data, exactly 4 accepted beats in order 0,1,2,3, line_wdone 1 cycle after the last beat.
- Busy drop: line_read issued during WR_BEAT. Required: ignored, proto_err=1, write completes normally.
- Simultaneous request: line_read and line_write in the same IDLE cycle. Required: write burst runs, proto_err=1, no line_rvalid.
- Async reset after 2 read beats. Required: all outputs 0 without waiting for a clock edge. The next read fills 4 fresh beats, with no stale data or response.
- With the macro: bmem_raddr=0x00000040 while addr_q=0x00000020. Required: proto_err set on that beat. Without the macro: proto_err stays 0.
